sprite_compositor: RTL
======================

# sprite_compositor

Parametrised sprite compositor: successor to the single-frog/fixed-lane sprite display. It overlays up to `NUM_SPRITES` sprites on the background stream, each with its own position, image index and orientation mode. It sits between the VGA sync counters / background generator and the VGA pins, and drives one external sprite memory.
- Sprite attributes are double-buffered and committed once per frame.
- Bounding-box collisions against sprite 0 (the player) are reported once per frame.

## Interface
- `NUM_SPRITES`, 8, number of sprite slots; slot 0 has highest priority and is the player.
- `TILE_SIZE`, 32, sprite edge in pixels; power of two.
- `NUM_IMAGES`, 4, sprite images stored back-to-back in the sprite memory.
- `PIXEL_W`, 9, RGB333 pixel width.
- `TRANSPARENT`, 9'b111101110, colour key treated as see-through.
- `H_VISIBLE_AREA`, 640, visible columns.
- `V_VISIBLE_AREA`, 480, visible lines.
- `i_Clk`  in  1  pixel clock; single clock domain.
- `i_Rst_N`  in  1  reset, asynchronous assert, active-low.
- `i_H_Counter`  in  10  current column.
- `i_V_Counter`  in  10  current line.
- `i_Background_Pixel`  in  PIXEL_W  background for the same (H,V) as the counters.
- `i_Attr_Wr_En`  in  1  write one shadow attribute slot.
- `i_Attr_Index`  in  clog2(NUM_SPRITES)  slot to write.
- `i_Attr_X`  in  10  left column.
- `i_Attr_Y`  in  10  top line.
- `i_Attr_Image`  in  clog2(NUM_IMAGES)  image select.
- `i_Attr_Mode`  in  3  [0] flip H, [1] flip V, [2] transpose.
- `i_Attr_Enable`  in  1  slot visible.
- `o_Rom_Addr`  out  clog2(NUM_IMAGES·TILE_SIZE²)  sprite memory read address.
- `i_Rom_Data`  in  PIXEL_W  sprite memory data, valid exactly 1 cycle after the address.
- `o_Pixel`  out  PIXEL_W  composited pixel.
- `o_Hit_Index`  out  clog2(NUM_SPRITES)+1  MSB = any sprite hit; low bits = winning slot.
- `o_Collision`  out  NUM_SPRITES  per-slot overlap with slot 0 in the last frame; bit 0 is always 0.
- `o_Frame_Commit`  out  1  one-cycle pulse when shadow attributes become active.

## Operation
- **Shadow/active banks.**
  - Writes land in the shadow bank only.
  - All shadow slots copy to the active bank in the single cycle where H=0 and V=V_VISIBLE_AREA. `o_Frame_Commit` pulses that cycle.
  - A write in the commit cycle lands in shadow and is applied at the next commit.
- **Hit test** per active, enabled slot: X ≤ H < X+TILE_SIZE and Y ≤ V < Y+TILE_SIZE. Compare at 11-bit width so X+TILE_SIZE never wraps; sprites crossing the right or bottom edge are clipped.
- **Priority.** The lowest-index hitting slot wins. Only the winner is fetched; if its texel equals `TRANSPARENT`, the background is shown (no fall-through to lower-priority slots).
- **Address.**
  - Offsets: dx=H−X, dy=V−Y, each clog2(TILE_SIZE) bits.
  - Transforms apply in order: transpose (swap dx,dy), then flip H (dx←TILE_SIZE−1−dx), then flip V (likewise dy).
  - Addr = Image·TILE_SIZE² + dy·TILE_SIZE + dx.
- **Outside the visible area:** `o_Pixel` = 0 and `o_Hit_Index` = 0.
- **Collision.**
  - During the visible frame, a sticky flag k sets whenever slot 0 and slot k both hit the same pixel.
  - At commit, the flags copy to `o_Collision` and the sticky flags clear.
  - Disabled slots never set a flag.

## Timing
- Pipeline has three stages; pixel latency is 3 cycles from counters to `o_Pixel`/`o_Hit_Index`:
  - S1: register counters and background.
  - S2: hit, priority and address; `o_Rom_Addr` is registered here.
  - S3: ROM data returns; key compare and mux into the output register.
- Background and visibility are delayed internally to match the 3-cycle latency. The surrounding sync logic must delay HSYNC/VSYNC by 3 cycles.
- `o_Collision` updates in the same cycle as the `o_Frame_Commit` pulse. The pulse itself is not pipelined.
- **Reset** (asynchronous, any time including mid-line):
  - All attribute slots are disabled, with X=Y=Image=Mode=0.
  - `o_Pixel`=0, `o_Hit_Index`=0, `o_Collision`=0, `o_Frame_Commit`=0, `o_Rom_Addr`=0.
  - Pipeline valid bits clear.
  - Normal output resumes 3 cycles after release.

## Structure
- **Package `sprite_pkg`:**
  - Attribute struct {x, y, image, mode, enable}.
  - Mode bit positions.
  - `TRANSPARENT` default.
  - RGB333 field offsets, so the top level splits `o_Pixel` to VGA pins as [8:6] red, [5:3] green, [2:0] blue.
- **Sub-module `sprite_hit_unit`:** combinational hit + offset + transform for one slot. Instantiate it `NUM_SPRITES` times with a generate loop.
- The priority encoder, banks, pipeline and collision logic live in the top module.

## Test plan
- **Reset:** hold `i_Rst_N`=0 mid-frame → all outputs 0; after release with no sprites enabled, `o_Pixel` equals the background delayed 3 cycles.
- **Single sprite:** slot 2 at (100,50), image 1, mode 0, committed. At H=105,V=52 → `o_Rom_Addr`=1024+2·32+5=1093 one cycle later; ROM data 9'h1C0 appears on `o_Pixel` 3 cycles after the counters; `o_Hit_Index`=4'b1010.
- **Transparency and edges:** ROM returns `TRANSPARENT` → background shown. H=132 (X+TILE_SIZE) → no hit. Sprite at X=620 → no hit at H≥640.
- **Priority and modes:** slots 1 and 3 overlap → slot 1 wins. Mode 3'b100 at dx=5, dy=2 → addr offset 5·32+2=162. Mode 3'b011 → offset 29·32+26=954.
- **Double-buffering:** a write to slot 0 mid-frame changes nothing until the H=0,V=480 cycle; `o_Frame_Commit` pulses exactly once there.
- **Collision:** slots 0 and 4 overlap for one frame → `o_Collision`=8'b0001_0000 at the next commit; it clears to 0 at the following commit once the sprites are separated.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor.
// Attribute record, mode bit positions and RGB333 field layout.
package sprite_pkg;

    localparam int COORD_W = 10;
    localparam int IMAGE_W = 8;

    localparam int MODE_FLIP_H    = 0;
    localparam int MODE_FLIP_V    = 1;
    localparam int MODE_TRANSPOSE = 2;

    localparam logic [8:0] TRANSPARENT_DEFAULT = 9'b111101110;

    // RGB333: [8:6] red, [5:3] green, [2:0] blue
    localparam int CHANNEL_W = 3;
    localparam int RED_LSB   = 6;
    localparam int GREEN_LSB = 3;
    localparam int BLUE_LSB  = 0;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [IMAGE_W-1:0] image;
        logic [2:0]         mode;
        logic               enable;
    } sprite_attr_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// Attribute write bundle for the sprite compositor.
// The CPU side drives it as master; the compositor reads it as slave.
interface sprite_compositor_if #(
    parameter int IDX_W = 3,
    parameter int IMG_W = 2
);
    logic             wr_en;
    logic [IDX_W-1:0] index;
    logic [9:0]       x;
    logic [9:0]       y;
    logic [IMG_W-1:0] image;
    logic [2:0]       mode;
    logic             enable;

    modport master (
        output wr_en, index, x, y, image, mode, enable
    );
    modport slave (
        input wr_en, index, x, y, image, mode, enable
    );
endinterface

// File: rtl/sprite_hit_unit.sv
// Per-slot bounding-box test and texel address generation.
// Purely combinational; one instance per sprite slot.
module sprite_hit_unit
    import sprite_pkg::*;
#(
    parameter int TILE_SIZE = 32,
    parameter int ADDR_W    = 12
) (
    input  logic [9:0]        h,
    input  logic [9:0]        v,
    input  sprite_attr_t      attr,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);

    localparam int OFF_W = $clog2(TILE_SIZE);

    logic [10:0]      h_w, v_w, x_lo, y_lo, x_hi, y_hi;
    logic [OFF_W-1:0] dx0, dy0, dx1, dy1, dx, dy;

    // 11-bit compare so X+TILE_SIZE cannot wrap past 1023
    assign h_w  = {1'b0, h};
    assign v_w  = {1'b0, v};
    assign x_lo = {1'b0, attr.x};
    assign y_lo = {1'b0, attr.y};
    assign x_hi = x_lo + 11'(TILE_SIZE);
    assign y_hi = y_lo + 11'(TILE_SIZE);

    assign hit = attr.enable
              && (h_w >= x_lo) && (h_w < x_hi)
              && (v_w >= y_lo) && (v_w < y_hi);

    assign dx0 = OFF_W'(h - attr.x);
    assign dy0 = OFF_W'(v - attr.y);

    assign dx1 = attr.mode[MODE_TRANSPOSE] ? dy0 : dx0;
    assign dy1 = attr.mode[MODE_TRANSPOSE] ? dx0 : dy0;

    // TILE_SIZE-1-d is a bitwise invert for a power-of-two tile
    assign dx = attr.mode[MODE_FLIP_H] ? ~dx1 : dx1;
    assign dy = attr.mode[MODE_FLIP_V] ? ~dy1 : dy1;

    assign addr = ADDR_W'(attr.image) * ADDR_W'(TILE_SIZE * TILE_SIZE)
                + ADDR_W'(dy) * ADDR_W'(TILE_SIZE)
                + ADDR_W'(dx);

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite overlay on the background stream, 3-cycle pixel latency.
// Double-buffered attributes, lowest-slot priority, player collision flags.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int                 NUM_SPRITES    = 8,
    parameter int                 TILE_SIZE      = 32,
    parameter int                 NUM_IMAGES     = 4,
    parameter int                 PIXEL_W        = 9,
    parameter logic [PIXEL_W-1:0] TRANSPARENT    = TRANSPARENT_DEFAULT,
    parameter int                 H_VISIBLE_AREA = 640,
    parameter int                 V_VISIBLE_AREA = 480
) (
    input  logic                                            i_Clk,
    input  logic                                            i_Rst_N,
    input  logic [9:0]                                      i_H_Counter,
    input  logic [9:0]                                      i_V_Counter,
    input  logic [PIXEL_W-1:0]                              i_Background_Pixel,
    input  logic                                            i_Attr_Wr_En,
    input  logic [$clog2(NUM_SPRITES)-1:0]                  i_Attr_Index,
    input  logic [9:0]                                      i_Attr_X,
    input  logic [9:0]                                      i_Attr_Y,
    input  logic [$clog2(NUM_IMAGES)-1:0]                   i_Attr_Image,
    input  logic [2:0]                                      i_Attr_Mode,
    input  logic                                            i_Attr_Enable,
    output logic [$clog2(NUM_IMAGES*TILE_SIZE*TILE_SIZE)-1:0] o_Rom_Addr,
    input  logic [PIXEL_W-1:0]                              i_Rom_Data,
    output logic [PIXEL_W-1:0]                              o_Pixel,
    output logic [$clog2(NUM_SPRITES):0]                    o_Hit_Index,
    output logic [NUM_SPRITES-1:0]                          o_Collision,
    output logic                                            o_Frame_Commit
);

    localparam int IDX_W  = $clog2(NUM_SPRITES);
    localparam int ADDR_W = $clog2(NUM_IMAGES * TILE_SIZE * TILE_SIZE);

    sprite_attr_t shadow [NUM_SPRITES];
    sprite_attr_t active [NUM_SPRITES];

    logic commit;
    assign commit = (i_H_Counter == 10'd0)
                 && (i_V_Counter == 10'(V_VISIBLE_AREA));

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (commit) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (i_Attr_Wr_En && (int'(i_Attr_Index) < NUM_SPRITES)) begin
                shadow[i_Attr_Index] <= '{
                    x:      i_Attr_X,
                    y:      i_Attr_Y,
                    image:  IMAGE_W'(i_Attr_Image),
                    mode:   i_Attr_Mode,
                    enable: i_Attr_Enable
                };
            end
        end
    end

    logic [9:0]         h1, v1;
    logic [PIXEL_W-1:0] bg1;
    logic               vld1;

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            h1   <= '0;
            v1   <= '0;
            bg1  <= '0;
            vld1 <= 1'b0;
        end else begin
            h1   <= i_H_Counter;
            v1   <= i_V_Counter;
            bg1  <= i_Background_Pixel;
            vld1 <= 1'b1;
        end
    end

    logic [NUM_SPRITES-1:0] hit;
    logic [ADDR_W-1:0]      slot_addr [NUM_SPRITES];

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit_unit #(
            .TILE_SIZE (TILE_SIZE),
            .ADDR_W    (ADDR_W)
        ) u_hit (
            .h    (h1),
            .v    (v1),
            .attr (active[g]),
            .hit  (hit[g]),
            .addr (slot_addr[g])
        );
    end

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_addr;

    // Walk high to low so the lowest hitting slot is the last assignment
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_addr  = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_addr  = slot_addr[i];
            end
        end
    end

    logic vis1;
    assign vis1 = vld1
               && (h1 < 10'(H_VISIBLE_AREA))
               && (v1 < 10'(V_VISIBLE_AREA));

    logic               show2, hit2;
    logic [IDX_W-1:0]   idx2;
    logic [PIXEL_W-1:0] bg2;

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            o_Rom_Addr <= '0;
            show2      <= 1'b0;
            hit2       <= 1'b0;
            idx2       <= '0;
            bg2        <= '0;
        end else begin
            o_Rom_Addr <= win_addr;
            show2      <= vis1;
            hit2       <= vis1 && win_found;
            idx2       <= win_idx;
            bg2        <= bg1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            o_Pixel     <= '0;
            o_Hit_Index <= '0;
        end else begin
            if (!show2) begin
                o_Pixel <= '0;
            end else if (hit2 && (i_Rom_Data != TRANSPARENT)) begin
                o_Pixel <= i_Rom_Data;
            end else begin
                o_Pixel <= bg2;
            end
            o_Hit_Index <= hit2 ? {1'b1, idx2} : '0;
        end
    end

    logic [NUM_SPRITES-1:0] sticky, coll_now;

    always_comb begin
        coll_now = '0;
        if (vis1 && hit[0]) begin
            coll_now = hit;
        end
        coll_now[0] = 1'b0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            sticky         <= '0;
            o_Collision    <= '0;
            o_Frame_Commit <= 1'b0;
        end else begin
            o_Frame_Commit <= commit;
            if (commit) begin
                o_Collision <= sticky | coll_now;
                sticky      <= '0;
            end else begin
                sticky <= sticky | coll_now;
            end
        end
    end

endmodule
